// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register. It drives a req/ack data-memory port and aligns
// load/store byte lanes. It stalls while a request is pending and aborts requests that never complete.
module mem_wb_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [2:0]  LoadTypeM,
  input  logic [1:0]  StoreTypeM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  WriteRegM,
  output logic        DmReq,
  output logic        DmWe,
  output logic [31:0] DmAddr,
  output logic [3:0]  DmBe,
  output logic [31:0] DmWData,
  input  logic        DmAck,
  input  logic [31:0] DmRData,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [4:0]  WriteRegW,
  output logic        AddrErrW,
  output logic        BusErrW
);
  // The first request cycle is spent in IDLE, so WAIT aborts after TIMEOUT-1 further cycles.
  localparam logic [7:0] WAIT_LIMIT = (TIMEOUT > 1) ? 8'(TIMEOUT - 1) : 8'd1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      stateReg, stateNext;
  logic [7:0]  waitCntReg, waitCntNext;
  logic [1:0]  off;
  logic        isWord, isHalf, accessM, misaligned, addrErr, timeout, retireOk;
  logic [15:0] loadHalf;
  logic [7:0]  loadByte;
  logic [31:0] loadData;

  assign off     = ALUOutM[1:0];
  assign accessM = MemtoRegM | MemWriteM;

  always_comb begin
    isWord = 1'b0;
    isHalf = 1'b0;
    if (MemWriteM) begin
      isWord = (StoreTypeM == 2'b00);
      isHalf = (StoreTypeM == 2'b01);
    end else begin
      isWord = (LoadTypeM == 3'b000) || (LoadTypeM > 3'b100);
      isHalf = (LoadTypeM == 3'b001) || (LoadTypeM == 3'b010);
    end
  end

  assign misaligned = isWord ? (off != 2'b00) : (isHalf & off[0]);
  assign addrErr    = accessM & misaligned;

  assign DmWe   = MemWriteM;
  assign DmAddr = {ALUOutM[31:2], 2'b00};

  always_comb begin
    DmBe    = 4'b1111;
    DmWData = WriteDataM;
    if (MemWriteM) begin
      if (isHalf) begin
        DmBe    = off[1] ? 4'b1100 : 4'b0011;
        DmWData = {2{WriteDataM[15:0]}};
      end else if (!isWord) begin
        DmBe    = 4'b0001 << off;
        DmWData = {4{WriteDataM[7:0]}};
      end
    end
  end

  assign loadHalf = off[1] ? DmRData[31:16] : DmRData[15:0];
  assign loadByte = DmRData[8*off +: 8];

  always_comb begin
    case (LoadTypeM)
      3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
      3'b010:  loadData = {16'h0000, loadHalf};
      3'b011:  loadData = {{24{loadByte[7]}}, loadByte};
      3'b100:  loadData = {24'h000000, loadByte};
      default: loadData = DmRData;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg   <= S_IDLE;
      waitCntReg <= '0;
    end else begin
      stateReg   <= stateNext;
      waitCntReg <= waitCntNext;
    end
  end

  always_comb begin
    stateNext   = stateReg;
    waitCntNext = waitCntReg;
    case (stateReg)
      S_IDLE: begin
        if (DmReq && !DmAck) begin
          stateNext   = S_WAIT;
          waitCntNext = 8'd1;
        end
      end
      S_WAIT: begin
        if (DmAck || timeout) begin
          stateNext   = S_IDLE;
          waitCntNext = '0;
        end else begin
          waitCntNext = waitCntReg + 8'd1;
        end
      end
      default: begin
        stateNext   = S_IDLE;
        waitCntNext = '0;
      end
    endcase
  end

  // Reset gates the request combinationally so an in-flight access is dropped without a clock.
  always_comb begin
    DmReq = 1'b0;
    if (!reset) DmReq = (stateReg == S_WAIT) || (accessM && !misaligned);
    timeout = (stateReg == S_WAIT) && (waitCntReg == WAIT_LIMIT) && !DmAck;
    StallM  = DmReq && !DmAck && !timeout;
  end

  assign retireOk = !addrErr && !timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      ReadDataW <= '0;
      ALUOutW   <= '0;
      WriteRegW <= '0;
      AddrErrW  <= 1'b0;
      BusErrW   <= 1'b0;
    end else if (StallM) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      AddrErrW  <= 1'b0;
      BusErrW   <= 1'b0;
    end else begin
      RegWriteW <= RegWriteM && retireOk;
      MemtoRegW <= MemtoRegM && retireOk;
      ReadDataW <= (MemtoRegM && retireOk) ? loadData : 32'h0;
      ALUOutW   <= ALUOutM;
      WriteRegW <= WriteRegM;
      AddrErrW  <= addrErr;
      BusErrW   <= timeout;
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized transactions checked
// against an arithmetic reference model of access size, lane selection, latency and timeout.
module tb_mem_wb_stage;
  localparam int TO    = 4;
  localparam int NOACK = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteM, MemtoRegM, MemWriteM;
  logic [2:0]  LoadTypeM;
  logic [1:0]  StoreTypeM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;
  logic        DmReq, DmWe, DmAck;
  logic [31:0] DmAddr, DmWData, DmRData;
  logic [3:0]  DmBe;
  logic        StallM, RegWriteW, MemtoRegW, AddrErrW, BusErrW;
  logic [31:0] ReadDataW, ALUOutW;
  logic [4:0]  WriteRegW;

  int nCmp = 0, nFail = 0;
  int cycleCnt = 0;

  logic        oReq, oWe, oHung;
  logic [31:0] oAddr, oWData;
  logic [3:0]  oBe;
  int          oStalls, oBubbles;

  mem_wb_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .LoadTypeM(LoadTypeM), .StoreTypeM(StoreTypeM), .ALUOutM(ALUOutM),
    .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .DmReq(DmReq), .DmWe(DmWe), .DmAddr(DmAddr), .DmBe(DmBe), .DmWData(DmWData),
    .DmAck(DmAck), .DmRData(DmRData), .StallM(StallM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ReadDataW(ReadDataW),
    .ALUOutW(ALUOutW), .WriteRegW(WriteRegW), .AddrErrW(AddrErrW), .BusErrW(BusErrW)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Reference model: access size in bytes decides alignment and lane placement.
  function automatic int accSize(input logic st, input logic [2:0] lt, input logic [1:0] stt);
    if (st) return (stt == 2'd0) ? 4 : (stt == 2'd1) ? 2 : 1;
    return (lt == 3'd0) ? 4 : (lt <= 3'd2) ? 2 : 1;
  endfunction

  function automatic logic refMis(input logic ld, input logic st, input logic [2:0] lt,
                                  input logic [1:0] stt, input logic [31:0] addr);
    int a;
    a = int'(addr[1:0]);
    if (!ld && !st) return 1'b0;
    return (a % accSize(st, lt, stt)) != 0;
  endfunction

  function automatic logic [31:0] refLoad(input logic [2:0] lt, input logic [31:0] addr,
                                          input logic [31:0] word);
    int a;
    logic [31:0] v;
    a = int'(addr[1:0]);
    if (lt == 3'd0) return word;
    if (lt <= 3'd2) begin
      v = (word >> (16 * (a / 2))) & 32'hFFFF;
      if (lt == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = (word >> (8 * a)) & 32'hFF;
      if (lt == 3'd3 && v >= 32'h80) v = v - 32'h100;
    end
    return v;
  endfunction

  function automatic logic [3:0] refBe(input logic [1:0] stt, input logic [31:0] addr);
    int a;
    a = int'(addr[1:0]);
    if (stt == 2'd0) return 4'hF;
    if (stt == 2'd1) return (a < 2) ? 4'h3 : 4'hC;
    return 4'(1 << a);
  endfunction

  function automatic logic [31:0] refWData(input logic [1:0] stt, input logic [31:0] wd);
    if (stt == 2'd0) return wd;
    if (stt == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return (wd & 32'hFF) * 32'h0101_0101;
  endfunction

  // Presents one M-stage instruction (entered at posedge+1), acks on cycle 'lat', returns after it retires.
  task automatic run_txn(input logic rw, input logic ld, input logic st, input logic [2:0] lt,
                         input logic [1:0] stt, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] wr, input int lat, input logic [31:0] rdata);
    int idx;
    logic stalled;
    RegWriteM = rw; MemtoRegM = ld; MemWriteM = st; LoadTypeM = lt; StoreTypeM = stt;
    ALUOutM = alu; WriteDataM = wd; WriteRegM = wr;
    oStalls = 0; oBubbles = 0; oHung = 1'b0; idx = 0;
    forever begin
      DmAck   = (idx == lat);
      DmRData = (idx == lat) ? rdata : $urandom;
      #4;
      if (idx == 0) begin
        oReq = DmReq; oWe = DmWe; oAddr = DmAddr; oBe = DmBe; oWData = DmWData;
      end
      stalled = StallM;
      @(posedge clk); #1;
      if (!stalled) break;
      oStalls++;
      if (!RegWriteW && !MemtoRegW && !AddrErrW && !BusErrW) oBubbles++;
      idx++;
      if (idx > 20) begin oHung = 1'b1; break; end
    end
    DmAck = 1'b0;
  endtask

  task automatic test_reset();
    RegWriteM = 1; MemtoRegM = 1; MemWriteM = 0; LoadTypeM = 0; ALUOutM = 32'h40; WriteRegM = 5'd4;
    repeat (2) @(posedge clk);
    #1;
    nCmp++; if ({DmReq, StallM} !== 2'b00) begin nFail++; $display("FAIL rst_req_stall: got %b want 00", {DmReq, StallM}); end
    nCmp++; if ({RegWriteW, MemtoRegW, AddrErrW, BusErrW} !== 4'b0) begin nFail++; $display("FAIL rst_wflags: got %b want 0000", {RegWriteW, MemtoRegW, AddrErrW, BusErrW}); end
    nCmp++; if ({ReadDataW, ALUOutW, WriteRegW} !== 69'b0) begin nFail++; $display("FAIL rst_wdata: got %h %h %h want 0", ReadDataW, ALUOutW, WriteRegW); end
    reset = 1'b0;
  endtask

  task automatic test_load_byte();
    run_txn(1, 1, 0, 3'b011, 2'b00, 32'h1003, 32'h0, 5'd3, 0, 32'h80FF_1234);
    nCmp++; if (oStalls != 0) begin nFail++; $display("FAIL lb_stalls: got %0d want 0", oStalls); end
    nCmp++; if (ReadDataW !== 32'hFFFF_FF80) begin nFail++; $display("FAIL lb_rdata: got %h want ffffff80", ReadDataW); end
    nCmp++; if ({RegWriteW, MemtoRegW, WriteRegW} !== {2'b11, 5'd3}) begin nFail++; $display("FAIL lb_wctl: got %b want 1100011", {RegWriteW, MemtoRegW, WriteRegW}); end
  endtask

  task automatic test_store_wait();
    run_txn(0, 0, 1, 3'b000, 2'b01, 32'h2002, 32'h0000_ABCD, 5'd0, 3, 32'h0);
    nCmp++; if ({oReq, oWe, oBe} !== 6'b11_1100) begin nFail++; $display("FAIL sh_req_be: got %b want 111100", {oReq, oWe, oBe}); end
    nCmp++; if (oWData !== 32'hABCD_ABCD) begin nFail++; $display("FAIL sh_wdata: got %h want abcdabcd", oWData); end
    nCmp++; if (oAddr !== 32'h2000) begin nFail++; $display("FAIL sh_addr: got %h want 00002000", oAddr); end
    nCmp++; if (oStalls != 3 || oBubbles != 3) begin nFail++; $display("FAIL sh_stall: got %0d stalls %0d bubbles want 3/3", oStalls, oBubbles); end
    nCmp++; if ({RegWriteW, MemtoRegW, AddrErrW, BusErrW} !== 4'b0) begin nFail++; $display("FAIL sh_retire: got %b want 0000", {RegWriteW, MemtoRegW, AddrErrW, BusErrW}); end
  endtask

  task automatic test_misaligned();
    run_txn(1, 1, 0, 3'b000, 2'b00, 32'h0001, 32'h0, 5'd5, NOACK, 32'h0);
    nCmp++; if (oReq !== 1'b0 || oStalls != 0) begin nFail++; $display("FAIL mis_req: got req %b stalls %0d want 0/0", oReq, oStalls); end
    nCmp++; if ({AddrErrW, RegWriteW, MemtoRegW} !== 3'b100) begin nFail++; $display("FAIL mis_w: got %b want 100", {AddrErrW, RegWriteW, MemtoRegW}); end
    run_txn(1, 0, 0, 3'b000, 2'b00, 32'h55, 32'h0, 5'd6, NOACK, 32'h0);
    nCmp++; if (AddrErrW !== 1'b0) begin nFail++; $display("FAIL mis_pulse: got %b want 0", AddrErrW); end
  endtask

  task automatic test_timeout();
    run_txn(1, 1, 0, 3'b010, 2'b00, 32'h30, 32'h0, 5'd8, NOACK, 32'h0);
    nCmp++; if (oStalls != TO - 1 || oHung) begin nFail++; $display("FAIL to_stalls: got %0d hung %b want %0d", oStalls, oHung, TO - 1); end
    nCmp++; if ({BusErrW, RegWriteW, MemtoRegW} !== 3'b100) begin nFail++; $display("FAIL to_w: got %b want 100", {BusErrW, RegWriteW, MemtoRegW}); end
    // ALU op with a stray ack: no request may appear and the error pulse must be gone
    run_txn(1, 0, 0, 3'b000, 2'b00, 32'h77, 32'h0, 5'd9, 0, 32'h0);
    nCmp++; if (oReq !== 1'b0 || oStalls != 0) begin nFail++; $display("FAIL to_after: got req %b stalls %0d want 0/0", oReq, oStalls); end
    nCmp++; if ({BusErrW, RegWriteW, ALUOutW} !== {2'b01, 32'h77}) begin nFail++; $display("FAIL to_pulse: got %b %b %h want 0 1 00000077", BusErrW, RegWriteW, ALUOutW); end
    run_txn(1, 1, 0, 3'b010, 2'b00, 32'h32, 32'h0, 5'd10, TO - 1, 32'hBEEF_0000);
    nCmp++; if (oStalls != TO - 1 || BusErrW !== 1'b0) begin nFail++; $display("FAIL to_lastack: got %0d stalls buserr %b want %0d/0", oStalls, BusErrW, TO - 1); end
    nCmp++; if (ReadDataW !== 32'h0000_BEEF) begin nFail++; $display("FAIL to_lastdata: got %h want 0000beef", ReadDataW); end
  endtask

  task automatic test_reset_in_wait();
    run_txn(1, 0, 0, 3'b000, 2'b00, 32'h1234_5678, 32'h0, 5'd7, NOACK, 32'h0);
    RegWriteM = 1; MemtoRegM = 1; MemWriteM = 0; LoadTypeM = 0; ALUOutM = 32'h100; WriteRegM = 5'd9;
    DmAck = 0;
    repeat (2) begin @(posedge clk); #1; end
    nCmp++; if ({DmReq, StallM} !== 2'b11) begin nFail++; $display("FAIL rw_wait: got %b want 11", {DmReq, StallM}); end
    #2 reset = 1'b1;
    #1;
    nCmp++; if ({DmReq, StallM} !== 2'b00) begin nFail++; $display("FAIL rw_async_req: got %b want 00", {DmReq, StallM}); end
    nCmp++; if ({RegWriteW, MemtoRegW, AddrErrW, BusErrW, ReadDataW, ALUOutW, WriteRegW} !== 73'b0) begin nFail++; $display("FAIL rw_async_w: got aluout %h wreg %h want 0", ALUOutW, WriteRegW); end
    @(posedge clk); #1;
    reset = 1'b0;
    run_txn(1, 1, 0, 3'b000, 2'b00, 32'h100, 32'h0, 5'd9, 1, 32'hCAFE_F00D);
    nCmp++; if (oStalls != 1 || ReadDataW !== 32'hCAFE_F00D) begin nFail++; $display("FAIL rw_after: got %0d stalls data %h want 1/cafef00d", oStalls, ReadDataW); end
    nCmp++; if ({RegWriteW, MemtoRegW, WriteRegW} !== {2'b11, 5'd9}) begin nFail++; $display("FAIL rw_after_ctl: got %b want 1101001", {RegWriteW, MemtoRegW, WriteRegW}); end
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = cycleCnt;
    run_txn(1, 1, 0, 3'b100, 2'b00, 32'h2, 32'h0, 5'd1, 0, 32'h11AA_2233);
    nCmp++; if (ReadDataW !== 32'h0000_00AA || oStalls != 0) begin nFail++; $display("FAIL b2b_lbu: got %h stalls %0d want 000000aa/0", ReadDataW, oStalls); end
    run_txn(1, 1, 0, 3'b001, 2'b00, 32'h6, 32'h0, 5'd2, 0, 32'h8001_7FFF);
    nCmp++; if (ReadDataW !== 32'hFFFF_8001 || oStalls != 0) begin nFail++; $display("FAIL b2b_lh: got %h stalls %0d want ffff8001/0", ReadDataW, oStalls); end
    run_txn(0, 0, 1, 3'b000, 2'b00, 32'h8, 32'hDEAD_BEEF, 5'd0, 0, 32'h0);
    nCmp++; if ({oBe, oWData} !== {4'hF, 32'hDEAD_BEEF}) begin nFail++; $display("FAIL b2b_sw: got be %h data %h want f/deadbeef", oBe, oWData); end
    nCmp++; if ({RegWriteW, MemtoRegW, ReadDataW} !== 34'b0) begin nFail++; $display("FAIL b2b_sw_w: got %b %b %h want 0 0 0", RegWriteW, MemtoRegW, ReadDataW); end
    nCmp++; if (cycleCnt - c0 != 3) begin nFail++; $display("FAIL b2b_cycles: got %0d want 3", cycleCnt - c0); end
  endtask

  task automatic test_random();
    logic ld, st, rw, mis, accOk, busErr, expRW, expM2R;
    logic [2:0] lt;
    logic [1:0] stt;
    logic [31:0] alu, wd, rdata, expRD;
    logic [4:0] wr;
    int kind, lat, expStalls;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      ld = (kind == 1); st = (kind == 2); rw = !st;
      lt = 3'($urandom_range(0, 4)); stt = 2'($urandom_range(0, 2));
      alu = $urandom;
      if ($urandom_range(0, 1) == 0) alu[1:0] = 2'b00;
      wd = $urandom; rdata = $urandom; wr = 5'($urandom_range(0, 31));
      lat = $urandom_range(0, 4);
      if (lat == 4) lat = NOACK;
      mis    = refMis(ld, st, lt, stt, alu);
      accOk  = (ld || st) && !mis;
      busErr = accOk && (lat >= TO);
      expStalls = accOk ? ((lat < TO) ? lat : TO - 1) : 0;
      expRW  = rw && !mis && !busErr;
      expM2R = ld && !mis && !busErr;
      expRD  = expM2R ? refLoad(lt, alu, rdata) : 32'h0;
      run_txn(rw, ld, st, lt, stt, alu, wd, wr, lat, rdata);
      nCmp++; if (oStalls != expStalls || oBubbles != expStalls) begin nFail++; $display("FAIL rnd_stall[%0d]: got %0d/%0d want %0d", i, oStalls, oBubbles, expStalls); end
      nCmp++; if (oReq !== accOk) begin nFail++; $display("FAIL rnd_req[%0d]: got %b want %b", i, oReq, accOk); end
      if (accOk) begin
        nCmp++; if ({oWe, oAddr} !== {st, alu[31:2], 2'b00}) begin nFail++; $display("FAIL rnd_addr[%0d]: got we %b addr %h want %b %h", i, oWe, oAddr, st, {alu[31:2], 2'b00}); end
      end
      if (accOk && st) begin
        nCmp++; if ({oBe, oWData} !== {refBe(stt, alu), refWData(stt, wd)}) begin nFail++; $display("FAIL rnd_store[%0d]: got be %h data %h want %h %h", i, oBe, oWData, refBe(stt, alu), refWData(stt, wd)); end
      end
      nCmp++; if ({RegWriteW, MemtoRegW, AddrErrW, BusErrW} !== {expRW, expM2R, mis, busErr}) begin nFail++; $display("FAIL rnd_wctl[%0d]: got %b want %b", i, {RegWriteW, MemtoRegW, AddrErrW, BusErrW}, {expRW, expM2R, mis, busErr}); end
      nCmp++; if (ReadDataW !== expRD) begin nFail++; $display("FAIL rnd_rdata[%0d]: got %h want %h (lt %0d addr %h word %h)", i, ReadDataW, expRD, lt, alu, rdata); end
      nCmp++; if ({ALUOutW, WriteRegW} !== {alu, wr}) begin nFail++; $display("FAIL rnd_wpass[%0d]: got %h %h want %h %h", i, ALUOutW, WriteRegW, alu, wr); end
    end
  endtask

  initial begin
    reset = 1'b1;
    RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0; LoadTypeM = 0; StoreTypeM = 0;
    ALUOutM = 0; WriteDataM = 0; WriteRegM = 0; DmAck = 0; DmRData = 0;
    @(posedge clk); #1;
    test_reset();
    test_load_byte();
    test_store_wait();
    test_misaligned();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time limit, want finished");
    $fatal(1, "watchdog expired");
  end
endmodule
